// File: rtl/dbg_pkg.sv
// Shared types for the debug halt controller: FSM states, dcsr.cause codes and the trigger bound.
// Halt-on-reset support is compiled in by defining DBG_RESETHALT_EN (see debug_halt_ctrl).
package dbg_pkg;

  localparam int unsigned N_TRIG_MAX = 16;
  localparam int unsigned CAUSE_W    = 3;

  typedef enum logic [2:0] {
    RUNNING    = 3'd0,
    WAIT_STALL = 3'd1,
    ENTERING   = 3'd2,
    HALTED     = 3'd3,
    RESUMING   = 3'd4,
    STEPPING   = 3'd5
  } dbg_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_EBREAK    = 3'd1,
    CAUSE_TRIGGER   = 3'd2,
    CAUSE_HALTREQ   = 3'd3,
    CAUSE_STEP      = 3'd4,
    CAUSE_RESETHALT = 3'd5
  } dbg_cause_e;

  // A single trigger still needs a 1-bit index port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Larger rank wins when an event arrives while an entry is already pending.
  function automatic logic [2:0] cause_rank(input dbg_cause_e c);
    case (c)
      CAUSE_RESETHALT: return 3'd5;
      CAUSE_TRIGGER:   return 3'd4;
      CAUSE_EBREAK:    return 3'd3;
      CAUSE_HALTREQ:   return 3'd2;
      CAUSE_STEP:      return 3'd1;
      default:         return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/debug_halt_ctrl_if.sv
// Event arbitration bus between the halt controller FSM and its cause arbiter.
interface debug_halt_ctrl_if #(
  parameter int unsigned N_TRIG = 4
);
  import dbg_pkg::*;

  localparam int unsigned IDX_W = idx_w(N_TRIG);

  // Purely combinational request/result bus, no valid/ready: the master presents
  // qualified events every cycle, the slave answers in the same cycle and any_ev
  // qualifies cause/trig_idx (both are don't-care-free zeros when any_ev is low).
  logic [N_TRIG-1:0] trig_hit;
  logic              ebreak_ev;
  logic              haltreq_ev;
  logic              step_ev;
  logic              any_ev;
  dbg_cause_e        cause;
  logic [IDX_W-1:0]  trig_idx;

  modport master (
    output trig_hit, ebreak_ev, haltreq_ev, step_ev,
    input  any_ev, cause, trig_idx
  );

  modport slave (
    input  trig_hit, ebreak_ev, haltreq_ev, step_ev,
    output any_ev, cause, trig_idx
  );

endinterface

// File: rtl/dbg_cause_arb.sv
// Fixed-priority debug entry arbiter: trigger > ebreak > haltreq > step, lowest trigger index wins.
module dbg_cause_arb
  import dbg_pkg::*;
#(
  parameter int unsigned N_TRIG = 4
) (
  debug_halt_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(N_TRIG);
  localparam int unsigned N_EFF = (N_TRIG > N_TRIG_MAX) ? N_TRIG_MAX : N_TRIG;

  logic trig_any;

  always_comb begin
    trig_any     = |bus.trig_hit;
    bus.trig_idx = '0;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = int'(N_EFF) - 1; i >= 0; i--) begin
      if (bus.trig_hit[i]) bus.trig_idx = IDX_W'(i);
    end

    bus.any_ev = trig_any | bus.ebreak_ev | bus.haltreq_ev | bus.step_ev;
    bus.cause  = CAUSE_NONE;
    if (trig_any)            bus.cause = CAUSE_TRIGGER;
    else if (bus.ebreak_ev)  bus.cause = CAUSE_EBREAK;
    else if (bus.haltreq_ev) bus.cause = CAUSE_HALTREQ;
    else if (bus.step_ev)    bus.cause = CAUSE_STEP;
  end

endmodule

// File: rtl/debug_halt_ctrl.sv
// Debug halt/resume/single-step controller. Define DBG_RESETHALT_EN to enable halt-on-reset
// (cause 5) sampled in the first cycle after reset release.
module debug_halt_ctrl
  import dbg_pkg::*;
#(
  parameter int unsigned N_TRIG     = 4,
  parameter int unsigned STEP_CNT_W = 8,
  parameter int unsigned STALL_TO   = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      haltreq_i,
  input  logic                      resumereq_i,
  input  logic                      resethaltreq_i,
  input  logic                      step_en_i,
  input  logic [STEP_CNT_W-1:0]     step_count_i,
  input  logic                      instr_retire_i,
  input  logic [N_TRIG-1:0]         trig_match_i,
  input  logic [N_TRIG-1:0]         trig_en_i,
  input  logic                      ebreak_i,
  input  logic                      ebreakm_i,
  input  logic                      halted_i,
  output logic                      halt_req_o,
  output logic                      resume_req_o,
  output logic                      save_dpc_o,
  output logic [CAUSE_W-1:0]        cause_o,
  output logic [idx_w(N_TRIG)-1:0]  trig_idx_o,
  output logic                      debug_mode_o,
  output logic                      stall_timeout_o
);

  localparam int unsigned IDX_W = idx_w(N_TRIG);
  localparam int unsigned TO_W  = $clog2(STALL_TO + 1);

  dbg_state_e            state_q, state_d;
  dbg_cause_e            cause_q, cause_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  save_q, save_d;
  logic                  dbg_q, dbg_d;
  logic                  timeout_q;
  logic [TO_W-1:0]       wait_cnt_q;
  logic [STEP_CNT_W-1:0] step_cnt_q;
  logic [STEP_CNT_W-1:0] step_target;
  logic                  step_done;
  logic                  rh_go;

  debug_halt_ctrl_if #(.N_TRIG(N_TRIG)) arb_bus ();

  dbg_cause_arb #(.N_TRIG(N_TRIG)) u_arb (.bus(arb_bus.slave));

  // A programmed count of zero behaves as a single-instruction step.
  assign step_target = (step_count_i == '0) ? STEP_CNT_W'(1) : step_count_i;
  assign step_done   = (state_q == STEPPING) && instr_retire_i &&
                       (({1'b0, step_cnt_q} + {{STEP_CNT_W{1'b0}}, 1'b1}) >= {1'b0, step_target});

  assign arb_bus.trig_hit   = trig_match_i & trig_en_i;
  assign arb_bus.ebreak_ev  = ebreak_i & ebreakm_i;
  assign arb_bus.haltreq_ev = haltreq_i & ~dbg_q;
  assign arb_bus.step_ev    = step_done;

`ifdef DBG_RESETHALT_EN
  logic first_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) first_q <= 1'b1;
    else        first_q <= 1'b0;
  end

  assign rh_go = first_q & resethaltreq_i;
`else
  logic unused_resethaltreq;

  assign unused_resethaltreq = resethaltreq_i;
  assign rh_go               = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUNNING;
      cause_q <= CAUSE_NONE;
      idx_q   <= '0;
      save_q  <= 1'b0;
      dbg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      save_q  <= save_d;
      dbg_q   <= dbg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    idx_d   = idx_q;
    save_d  = 1'b0;
    dbg_d   = dbg_q;
    case (state_q)
      RUNNING, STEPPING: begin
        if (rh_go) begin
          state_d = ENTERING;
          cause_d = CAUSE_RESETHALT;
          idx_d   = '0;
          save_d  = ~dbg_q;
        end else if (arb_bus.any_ev) begin
          state_d = stall_i ? WAIT_STALL : ENTERING;
          cause_d = arb_bus.cause;
          idx_d   = arb_bus.trig_idx;
          save_d  = ~stall_i & ~dbg_q;
        end
      end
      WAIT_STALL: begin
        // Only a strictly higher-priority event replaces the pending cause.
        if (arb_bus.any_ev && (cause_rank(arb_bus.cause) > cause_rank(cause_q))) begin
          cause_d = arb_bus.cause;
          idx_d   = arb_bus.trig_idx;
        end
        if (!stall_i) begin
          state_d = ENTERING;
          save_d  = ~dbg_q;
        end
      end
      ENTERING: begin
        if (halted_i) begin
          state_d = HALTED;
          dbg_d   = 1'b1;
        end
      end
      HALTED: begin
        if (ebreak_i) begin
          state_d = ENTERING;
          cause_d = CAUSE_EBREAK;
          idx_d   = '0;
          save_d  = ~dbg_q;
        end else if (resumereq_i) begin
          state_d = RESUMING;
        end
      end
      RESUMING: begin
        if (!halted_i) begin
          state_d = step_en_i ? STEPPING : RUNNING;
          dbg_d   = 1'b0;
        end
      end
      default: state_d = RUNNING;
    endcase
  end

  // Timeout counts consecutive WAIT_STALL cycles; the flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == WAIT_STALL) begin
      if (wait_cnt_q != TO_W'(STALL_TO)) wait_cnt_q <= wait_cnt_q + TO_W'(1);
      if (wait_cnt_q == TO_W'(STALL_TO - 1)) timeout_q <= 1'b1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      step_cnt_q <= '0;
    end else if (state_q == STEPPING) begin
      if (instr_retire_i) step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
    end else begin
      step_cnt_q <= '0;
    end
  end

  assign halt_req_o      = (state_q == ENTERING);
  assign resume_req_o    = (state_q == RESUMING);
  assign save_dpc_o      = save_q;
  assign cause_o         = cause_q;
  assign trig_idx_o      = idx_q;
  assign debug_mode_o    = dbg_q;
  assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Directed + randomized bench for debug_halt_ctrl with a spec-level reference model.
module tb_debug_halt_ctrl;

  localparam int N_TRIG     = 4;
  localparam int STEP_CNT_W = 8;
  localparam int STALL_TO   = 3;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  stall_i, haltreq_i, resumereq_i, resethaltreq_i;
  logic                  step_en_i, instr_retire_i, ebreak_i, ebreakm_i, halted_i;
  logic [STEP_CNT_W-1:0] step_count_i;
  logic [N_TRIG-1:0]     trig_match_i, trig_en_i;
  logic                  halt_req_o, resume_req_o, save_dpc_o, debug_mode_o, stall_timeout_o;
  logic [2:0]            cause_o;
  logic [1:0]            trig_idx_o;

  int errors = 0;
  int checks = 0;
  int exp_cause, exp_idx, exp_to;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  debug_halt_ctrl #(.N_TRIG(N_TRIG), .STEP_CNT_W(STEP_CNT_W), .STALL_TO(STALL_TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .haltreq_i(haltreq_i),
    .resumereq_i(resumereq_i), .resethaltreq_i(resethaltreq_i), .step_en_i(step_en_i),
    .step_count_i(step_count_i), .instr_retire_i(instr_retire_i), .trig_match_i(trig_match_i),
    .trig_en_i(trig_en_i), .ebreak_i(ebreak_i), .ebreakm_i(ebreakm_i), .halted_i(halted_i),
    .halt_req_o(halt_req_o), .resume_req_o(resume_req_o), .save_dpc_o(save_dpc_o),
    .cause_o(cause_o), .trig_idx_o(trig_idx_o), .debug_mode_o(debug_mode_o),
    .stall_timeout_o(stall_timeout_o)
  );

  debug_halt_ctrl_if #(.N_TRIG(N_TRIG)) arb_bus ();
  dbg_cause_arb #(.N_TRIG(N_TRIG)) u_arb (.bus(arb_bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int halt, input int res, input int save,
                         input int cause, input int idx, input int dbg);
    chk({tag, ".halt_req"}, 32'(halt_req_o), halt);
    chk({tag, ".resume_req"}, 32'(resume_req_o), res);
    chk({tag, ".save_dpc"}, 32'(save_dpc_o), save);
    chk({tag, ".cause"}, 32'(cause_o), cause);
    chk({tag, ".trig_idx"}, 32'(trig_idx_o), idx);
    chk({tag, ".debug_mode"}, 32'(debug_mode_o), dbg);
    chk({tag, ".stall_timeout"}, 32'(stall_timeout_o), exp_to);
  endtask

  function automatic int lowest_set(input logic [N_TRIG-1:0] v);
    for (int i = 0; i < N_TRIG; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; haltreq_i = 0; resumereq_i = 0; resethaltreq_i = 0;
    step_en_i = 0; step_count_i = '0; instr_retire_i = 0;
    trig_match_i = '0; trig_en_i = '0; ebreak_i = 0; ebreakm_i = 0;
  endtask

  task automatic do_reset(input logic rh);
    idle();
    halted_i = 0;
    resethaltreq_i = rh;
    rst_i = 0;
    #1;
    exp_cause = 0; exp_idx = 0; exp_to = 0;
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    cycle();
    rst_i = 1;
  endtask

  task automatic go_halted();
    halted_i = 1;
    cycle();
    chk_out("halted", 0, 0, 0, exp_cause, exp_idx, 1);
  endtask

  task automatic resume(input logic se);
    step_en_i = se;
    resumereq_i = 1;
    cycle();
    resumereq_i = 0;
    chk_out("resuming", 0, 1, 0, exp_cause, exp_idx, 1);
    halted_i = 0;
    cycle();
    chk_out("resumed", 0, 0, 0, exp_cause, exp_idx, 0);
  endtask

  initial begin
    logic [N_TRIG-1:0] m, e, hit;
    logic eb, ebm, hr, st;
    int c, ix, len, tgt, n, j;
    bit ow;

    #300000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N_TRIG-1:0] m, e, hit;
    logic eb, ebm, hr, st;
    int c, ix, len, tgt, n, j;
    bit ow;

    rst_i = 0;
    idle();
    halted_i = 0;

    // Stand-alone arbiter: priority chain and lowest-index selection.
    for (int r = 0; r < 16; r++) begin
      hit = (r < 5) ? '0 : N_TRIG'($urandom_range(0, 15));
      eb = 1'($urandom_range(0, 1));
      hr = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      arb_bus.trig_hit = hit; arb_bus.ebreak_ev = eb; arb_bus.haltreq_ev = hr; arb_bus.step_ev = st;
      #1;
      ix = 0;
      if (hit != 0) begin c = 2; ix = lowest_set(hit); end
      else if (eb) c = 1;
      else if (hr) c = 3;
      else if (st) c = 4;
      else c = 0;
      chk("arb_any", 32'(arb_bus.any_ev), 32'((hit != 0) | eb | hr | st));
      chk("arb_cause", 32'(arb_bus.cause), c);
      chk("arb_idx", 32'(arb_bus.trig_idx), ix);
    end

    // Halt-on-reset sampled in the first cycle after release.
    do_reset(1);
    cycle();
    resethaltreq_i = 0;
`ifdef DBG_RESETHALT_EN
    exp_cause = 5;
    chk_out("resethalt", 1, 0, 1, 5, 0, 0);
    go_halted();
    resume(0);
`else
    chk_out("resethalt_ignored", 0, 0, 0, 0, 0, 0);
`endif

    // Trigger 0110 in RUNNING: index 1, cause 2, one save pulse.
    trig_match_i = 4'b0110; trig_en_i = 4'b1111;
    cycle();
    idle();
    exp_cause = 2; exp_idx = 1;
    chk_out("trig_0110", 1, 0, 1, 2, 1, 0);
    cycle();
    chk_out("trig_hold", 1, 0, 0, 2, 1, 0);
    go_halted();
    resume(0);

    resumereq_i = 1;
    cycle();
    resumereq_i = 0;
    chk_out("resume_noop", 0, 0, 0, exp_cause, exp_idx, 0);

    ebreak_i = 1; ebreakm_i = 0;
    cycle();
    idle();
    chk_out("ebreak_no_m", 0, 0, 0, exp_cause, exp_idx, 0);

    // Trigger and ebreak together: trigger wins.
    trig_match_i = 4'b1000; trig_en_i = 4'b1100; ebreak_i = 1; ebreakm_i = 1;
    cycle();
    idle();
    exp_cause = 2; exp_idx = 3;
    chk_out("trig_vs_ebreak", 1, 0, 1, 2, 3, 0);
    go_halted();

    haltreq_i = 1;
    cycle();
    haltreq_i = 0;
    chk_out("haltreq_in_debug", 0, 0, 0, exp_cause, exp_idx, 1);

    // ebreak while halted beats a simultaneous resume and re-enters without saving dpc.
    ebreak_i = 1; ebreakm_i = 1; resumereq_i = 1;
    cycle();
    idle();
    exp_cause = 1; exp_idx = 0;
    chk_out("ebreak_halted", 1, 0, 0, 1, 0, 1);
    go_halted();
    resume(0);

    // Random events while running.
    for (int r = 0; r < 12; r++) begin
      m = N_TRIG'($urandom_range(0, 15));
      e = N_TRIG'($urandom_range(0, 15));
      eb = 1'($urandom_range(0, 1));
      ebm = 1'($urandom_range(0, 1));
      hr = 1'($urandom_range(0, 1));
      trig_match_i = m; trig_en_i = e; ebreak_i = eb; ebreakm_i = ebm; haltreq_i = hr;
      hit = m & e;
      c = 0; ix = 0;
      if (hit != 0) begin c = 2; ix = lowest_set(hit); end
      else if (eb && ebm) c = 1;
      else if (hr) c = 3;
      cycle();
      idle();
      if (c != 0) begin
        exp_q.push_back(3'(c));
        exp_cause = c; exp_idx = ix;
        chk_out("rand_ev", 1, 0, 1, exp_cause, exp_idx, 0);
        chk("rand_cause_q", 32'(cause_o), 32'(exp_q.pop_front()));
        go_halted();
        resume(0);
      end else begin
        chk_out("rand_none", 0, 0, 0, exp_cause, exp_idx, 0);
      end
    end

    // Stall waits: len WAIT_STALL cycles, optional trigger overwrite mid-wait.
    for (int r = 0; r < 5; r++) begin
      len = (r == 0) ? 5 : (r == 1) ? 2 : (r == 2) ? 3 : $urandom_range(3, 6);
      ow = (r >= 3);
      do_reset(0);
      haltreq_i = 1; stall_i = 1;
      cycle();
      haltreq_i = 0;
      exp_cause = 3; exp_idx = 0;
      chk_out("wait_accept", 0, 0, 0, 3, 0, 0);
      for (int k = 1; k <= len; k++) begin
        if (k == len) stall_i = 0;
        if (ow && k == 2) begin
          j = $urandom_range(0, N_TRIG - 1);
          trig_match_i = N_TRIG'(1) << j; trig_en_i = '1;
        end
        cycle();
        trig_match_i = '0; trig_en_i = '0;
        if (ow && k == 2) begin exp_cause = 2; exp_idx = j; end
        if (k >= STALL_TO) exp_to = 1;
        if (k < len) chk_out("wait", 0, 0, 0, exp_cause, exp_idx, 0);
        else chk_out("enter_after_stall", 1, 0, 1, exp_cause, exp_idx, 0);
      end
      go_halted();
      resume(0);
    end

    // Multi-step: entry after max(step_count,1) retirements.
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 3 : (r == 1) ? 0 : $urandom_range(1, 6);
      tgt = (n == 0) ? 1 : n;
      haltreq_i = 1;
      cycle();
      idle();
      exp_cause = 3; exp_idx = 0;
      chk_out("pre_step_halt", 1, 0, 1, 3, 0, 0);
      go_halted();
      step_count_i = STEP_CNT_W'(n);
      resume(1);
      n = 0;
      for (int t = 0; t < 64 && n < tgt; t++) begin
        instr_retire_i = 1'($urandom_range(0, 1));
        cycle();
        if (instr_retire_i) n++;
        instr_retire_i = 0;
        if (n < tgt) chk("step_wait", 32'(halt_req_o), 0);
      end
      if (n < tgt) begin
        chk("step_budget", n, tgt);
      end else begin
        exp_cause = 4;
        chk_out("step_done", 1, 0, 1, 4, 0, 0);
      end
      idle();
      go_halted();
      resume(0);
    end

    // Reset asserted in ENTERING clears everything at once, nothing lingers after.
    trig_match_i = 4'b0001; trig_en_i = 4'b0001;
    cycle();
    idle();
    exp_cause = 2; exp_idx = 0;
    chk_out("pre_rst", 1, 0, 1, 2, 0, 0);
    rst_i = 0;
    #1;
    exp_cause = 0; exp_idx = 0; exp_to = 0;
    chk_out("rst_mid_enter", 0, 0, 0, 0, 0, 0);
    cycle();
    rst_i = 1;
    cycle();
    chk_out("post_rst", 0, 0, 0, 0, 0, 0);
    cycle();
    chk_out("post_rst2", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_halt_ctrl.md
DEBUG_HALT_CTRL -- requirements
Module: debug_halt_ctrl

Interface
REQ-001 SHALL have parameter N_TRIG, default 4, number of trigger-match inputs (1..16).
REQ-002 SHALL have parameter STEP_CNT_W, default 8, width of the multi-step instruction counter.
REQ-003 SHALL have parameter STALL_TO, default 1023, stall-wait cycles before the timeout flag is raised.
REQ-004 SHALL have ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  pipeline stall.
- haltreq_i  in  1  debug-module halt request, level.
- resumereq_i  in  1  debug-module resume request, pulse.
- resethaltreq_i  in  1  halt-on-reset request.
- step_en_i  in  1  dcsr.step.
- step_count_i  in  STEP_CNT_W  instructions per step; 0 means 1.
- instr_retire_i  in  1  one instruction retired this cycle.
- trig_match_i  in  N_TRIG  per-trigger match.
- trig_en_i  in  N_TRIG  per-trigger enable mask.
- ebreak_i  in  1  ebreak executed.
- ebreakm_i  in  1  dcsr.ebreakm.
- halted_i  in  1  pipeline is halted (acknowledge).
- halt_req_o  out  1  halt request to PC unit.
- resume_req_o  out  1  resume request to PC unit.
- save_dpc_o  out  1  one-cycle dpc capture strobe.
- cause_o  out  3  dcsr.cause of the current entry.
- trig_idx_o  out  clog2(N_TRIG)  index of the hitting trigger.
- debug_mode_o  out  1  core is in debug mode.
- stall_timeout_o  out  1  sticky stall-wait timeout.

Function
REQ-005 SHALL implement states RUNNING, WAIT_STALL, ENTERING, HALTED, RESUMING, STEPPING.
REQ-006 SHALL define an event as any of: (trig_match_i & trig_en_i) nonzero, ebreak_i with ebreakm_i, haltreq_i, or step completion.
REQ-007 SHALL transition from RUNNING or STEPPING on an event to ENTERING if stall_i is low, else to WAIT_STALL.
REQ-008 SHALL resolve simultaneous events by priority trigger > ebreak > haltreq > step, with causes trigger=2, ebreak=1, haltreq=3, step=4, resethalt=5, none=0.
REQ-009 SHALL select the lowest set index among simultaneously hitting triggers for trig_idx_o.
REQ-010 SHALL latch cause_o and trig_idx_o in the cycle the event is accepted and hold them until the next accepted event.
REQ-011 SHALL move WAIT_STALL to ENTERING on the first cycle stall_i is low; a higher-priority event arriving in WAIT_STALL SHALL overwrite the latched cause.
REQ-012 SHALL set stall_timeout_o after STALL_TO consecutive WAIT_STALL cycles, keep waiting, and clear it only on reset.
REQ-013 SHALL drive halt_req_o high in every ENTERING cycle (level, zero-cycle latency from state) and move to HALTED when halted_i is high.
REQ-014 SHALL pulse save_dpc_o for exactly one cycle on entry to ENTERING, only when debug_mode_o is low.
REQ-015 SHALL, in HALTED, on ebreak_i go to ENTERING (cause 1, no save_dpc_o), and on resumereq_i go to RESUMING; ebreak_i has priority.
REQ-016 SHALL drive resume_req_o high in every RESUMING cycle; when halted_i falls, go to STEPPING if step_en_i is high, else RUNNING.
REQ-017 SHALL, in STEPPING, count instr_retire_i pulses; reaching max(step_count_i,1) is step completion, and a lower count returns to STEPPING.
REQ-018 SHALL set debug_mode_o when HALTED is entered and clear it on RESUMING exit to RUNNING or STEPPING.
REQ-019 SHALL treat resumereq_i outside HALTED and haltreq_i while in debug mode as no-ops.

Reset
REQ-020 SHALL, on rst_i low, asynchronously force RUNNING, zero the step counter and timeout counter, and drive halt_req_o, resume_req_o, save_dpc_o, cause_o, trig_idx_o, debug_mode_o and stall_timeout_o to 0.
REQ-021 SHALL abandon any in-flight transition when reset is asserted mid-operation, with no residual output pulse after release.

Configuration
REQ-022 With DBG_RESETHALT_EN defined, SHALL sample resethaltreq_i in the first cycle after reset release and, if it is high, enter ENTERING with cause 5 and a save_dpc_o pulse.
REQ-023 Without DBG_RESETHALT_EN, SHALL ignore resethaltreq_i and never produce cause 5.

Structure
REQ-024 SHALL take the state enum, the cause codes (width 3) and the N_TRIG bound from shared package dbg_pkg.
REQ-025 SHALL place the priority/trigger-index arbitration in sub-module dbg_cause_arb.

Verification
REQ-026 trig_match_i=4'b0110, trig_en_i=4'b1111, stall_i=0 in RUNNING -> next cycle halt_req_o=1, cause_o=2, trig_idx_o=1, save_dpc_o pulses once.
REQ-027 haltreq_i with stall_i high for 5 cycles -> WAIT_STALL 5 cycles, then ENTERING, cause_o=3; with STALL_TO=3, stall_timeout_o=1 from the 4th stall cycle.
REQ-028 step_en_i=1, step_count_i=3, resume from HALTED -> halt_req_o rises after the 3rd instr_retire_i, cause_o=4.
REQ-029 ebreak_i, ebreakm_i=1 while HALTED -> ENTERING, cause_o=1, save_dpc_o stays 0.
REQ-030 Trigger and ebreak in the same cycle -> cause_o=2; rst_i low during ENTERING -> all outputs 0 immediately.
REQ-031 With DBG_RESETHALT_EN and resethaltreq_i=1 at reset release -> cause_o=5 and halt_req_o=1 in cycle 2.
